lram_readback: RTL and testbench

Sequential read-back engine for one LRAM_CORE-style block (16K x 32 in the default configuration). It is the read side counterpart to the LRAM configuration/write path. On a start command it sweeps a contiguous address window, issues one read per cycle into the memory port, absorbs the fixed read latency, and streams the words out on a valid/ready interface. Full throughput is maintained under backpressure without dropping or duplicating words. It sits between the LRAM instance and the bitstream/trace dump logic.

---
 rtl/lram_readback_if.sv | 35 +++
 rtl/lram_readback.sv | 153 +++++++++++++++
 tb/tb_lram_readback.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lram_readback_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : lram_readback_if
// Purpose  : Command, LRAM read port and output stream bundle for lram_readback.
// Revision : 1.0 - initial release
// ============================================================================
interface lram_readback_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
  logic              mem_ce;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    input  start, base_addr, count, mem_rdata, out_ready,
    output busy, done, mem_ce, mem_addr, out_valid, out_data, out_last
  );

  modport slave (
    output start, base_addr, count, mem_rdata, out_ready,
    input  busy, done, mem_ce, mem_addr, out_valid, out_data, out_last
  );
endinterface
`default_nettype wire

// File: rtl/lram_readback.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : lram_readback
// Purpose  : Credit-based sequential LRAM read-back engine streaming words out.
// Revision : 1.0 - initial release
// ============================================================================
module lram_readback #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  lram_readback_if.master bus
);
  localparam int              D      = RD_LAT + 2;
  localparam int              CW     = $clog2(D + 1);
  localparam logic [CW:0]     D_W    = D[CW:0];
  localparam logic [CW-1:0]   ONE_CW = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] ONE_A  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
  state_t state_q, state_d;

  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   count_q, count_d, issued_q, issued_d, rem_q, rem_d;
  logic [CW-1:0]     inflight_q, inflight_d, occ_q, occ_d, w_wr_idx;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [DATA_W-1:0] data_q [D];
  logic [DATA_W-1:0] data_d [D];
  logic [D-1:0]      last_q, last_d;
  logic              w_issue, w_push, w_pop, w_credit;

  // Credit ignores a same-cycle pop so every issued read owns a FIFO slot.
  assign w_credit = ({1'b0, inflight_q} + {1'b0, occ_q}) < D_W;
  assign w_issue  = (state_q == RUN) && (issued_q < count_q) && w_credit;
  assign w_push   = vld_q[RD_LAT-1];
  assign w_pop    = (occ_q != '0) && bus.out_ready;

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign vld_d = w_issue;
    end else begin : g_latn
      assign vld_d = {vld_q[RD_LAT-2:0], w_issue};
    end
  endgenerate

  assign bus.mem_ce    = w_issue;
  assign bus.mem_addr  = base_q + issued_q[ADDR_W-1:0];
  assign bus.out_valid = (occ_q != '0);
  assign bus.out_data  = data_q[0];
  assign bus.out_last  = last_q[0];

  always_comb begin
    state_d  = state_q;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      IDLE:  if (bus.start) state_d = (bus.count == '0) ? DONE : RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (w_issue && ((issued_q + ONE_A) == count_q)) state_d = DRAIN;
      end
      DRAIN: begin
        bus.busy = 1'b1;
        if (w_pop && last_q[0]) state_d = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    base_d     = base_q;
    count_d    = count_q;
    issued_d   = issued_q;
    rem_d      = rem_q;
    inflight_d = inflight_q;
    occ_d      = occ_q;
    data_d     = data_q;
    last_d     = last_q;
    w_wr_idx   = w_pop ? (occ_q - ONE_CW) : occ_q;

    if ((state_q == IDLE) && bus.start) begin
      base_d   = bus.base_addr;
      count_d  = bus.count;
      issued_d = '0;
      rem_d    = bus.count;
    end
    if (w_issue) issued_d = issued_q + ONE_A;
    if (w_push)  rem_d    = rem_q - ONE_A;

    case ({w_issue, w_push})
      2'b10:   inflight_d = inflight_q + ONE_CW;
      2'b01:   inflight_d = inflight_q - ONE_CW;
      default: ;
    endcase
    case ({w_push, w_pop})
      2'b10:   occ_d = occ_q + ONE_CW;
      2'b01:   occ_d = occ_q - ONE_CW;
      default: ;
    endcase

    // Shift-down FIFO keeps the head in entry 0 so the stream outputs are flops.
    if (w_pop) begin
      for (int i = 0; i < D - 1; i++) begin
        data_d[i] = data_q[i+1];
        last_d[i] = last_q[i+1];
      end
      data_d[D-1] = '0;
      last_d[D-1] = 1'b0;
    end
    if (w_push) begin
      for (int i = 0; i < D; i++) begin
        if (w_wr_idx == CW'(i)) begin
          data_d[i] = bus.mem_rdata;
          last_d[i] = (rem_q == ONE_A);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      rem_q      <= '0;
      inflight_q <= '0;
      occ_q      <= '0;
      vld_q      <= '0;
      last_q     <= '0;
      for (int i = 0; i < D; i++) data_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      vld_q      <= vld_d;
      last_q     <= last_d;
      data_q     <= data_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_lram_readback.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_lram_readback
// Purpose  : Directed scoreboard bench for lram_readback at RD_LAT=2 and RD_LAT=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lram_readback;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lram_readback_if #(.ADDR_W(14), .DATA_W(32)) if2 ();
  lram_readback_if #(.ADDR_W(14), .DATA_W(32)) if1 ();

  lram_readback #(.ADDR_W(14), .DATA_W(32), .RD_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  lram_readback #(.ADDR_W(14), .DATA_W(32), .RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  typedef struct packed { logic [31:0] d; logic l; } exp_t;
  exp_t        q2[$];
  exp_t        q1[$];
  logic [13:0] aq2[$];
  int checks = 0, failures = 0;
  int hs2 = 0, hs1 = 0, os2 = 0, max_os2 = 0, stall_viol = 0;
  logic        pv2 = 1'b0, pl2 = 1'b0;
  logic [31:0] pd2 = '0;
  logic [31:0] p2a = '0, p2b = '0, p1a = '0;

  function automatic logic [31:0] memv(input logic [13:0] a);
    return 32'hA500_0000 | {18'd0, a};
  endfunction

  // Memory models: data appears RD_LAT cycles after the enable cycle, garbage otherwise.
  always @(posedge clk) begin
    p2a <= (if2.mem_ce === 1'b1) ? memv(if2.mem_addr) : 32'hDEAD_BEEF;
    p2b <= p2a;
    p1a <= (if1.mem_ce === 1'b1) ? memv(if1.mem_addr) : 32'hDEAD_BEEF;
  end
  assign if2.mem_rdata = p2b;
  assign if1.mem_rdata = p1a;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (if2.mem_ce === 1'b1) aq2.push_back(if2.mem_addr);
    if (if2.out_valid === 1'b1 && if2.out_ready === 1'b1) begin
      hs2++;
      if (q2.size() == 0) chk("sb2_extra_word", 64'(q2.size()), 1);
      else begin
        e = q2.pop_front();
        chk("sb2_data", if2.out_data, e.d);
        chk("sb2_last", if2.out_last, e.l);
      end
    end
    if (rst) os2 = 0;
    else os2 = os2 + int'(if2.mem_ce === 1'b1) - int'(if2.out_valid === 1'b1 && if2.out_ready === 1'b1);
    if (os2 > max_os2) max_os2 = os2;
    if (pv2 && !rst && !(if2.out_valid === 1'b1 && if2.out_data === pd2 && if2.out_last === pl2))
      stall_viol++;
    pv2 = (if2.out_valid === 1'b1) && (if2.out_ready === 1'b0);
    pd2 = if2.out_data;
    pl2 = if2.out_last;
  end

  always @(negedge clk) begin
    exp_t e;
    if (if1.out_valid === 1'b1 && if1.out_ready === 1'b1) begin
      hs1++;
      if (q1.size() == 0) chk("sb1_extra_word", 64'(q1.size()), 1);
      else begin
        e = q1.pop_front();
        chk("sb1_data", if1.out_data, e.d);
        chk("sb1_last", if1.out_last, e.l);
      end
    end
  end

  task automatic start_cmd(input int lat, input logic [13:0] b, input logic [14:0] n);
    exp_t e;
    @(posedge clk); #1;
    for (int i = 0; i < int'(n); i++) begin
      e.d = memv(14'(int'(b) + i));
      e.l = (i == int'(n) - 1);
      if (lat == 2) q2.push_back(e); else q1.push_back(e);
    end
    if (lat == 2) begin if2.start = 1'b1; if2.base_addr = b; if2.count = n; end
    else          begin if1.start = 1'b1; if1.base_addr = b; if1.count = n; end
    @(posedge clk); #1;
    // Scribble the command inputs: they must have been sampled already.
    if (lat == 2) begin if2.start = 1'b0; if2.base_addr = 14'h2AAA; if2.count = 15'd5; end
    else          begin if1.start = 1'b0; if1.base_addr = 14'h2AAA; if1.count = 15'd5; end
  endtask

  task automatic wait_done(input int lat, input int budget, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if ((lat == 2 ? if2.done : if1.done) === 1'b1) found = 1'b1;
    end
    chk(tag, found, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, if2.busy, 0);
    chk({tag, "_done"}, if2.done, 0);
    chk({tag, "_ce"}, if2.mem_ce, 0);
    chk({tag, "_addr"}, if2.mem_addr, 0);
    chk({tag, "_valid"}, if2.out_valid, 0);
    chk({tag, "_data"}, if2.out_data, 0);
    chk({tag, "_last"}, if2.out_last, 0);
  endtask

  // Cycle-exact basic read of base 0x10, count 4; cycle 1 is the first busy cycle.
  task automatic basic_table(input int lat);
    logic ce, v, l, dn, bz, e_ce, e_v;
    logic [13:0] a;
    logic [31:0] d;
    start_cmd(lat, 14'h0010, 15'd4);
    for (int c = 1; c <= lat + 7; c++) begin
      @(negedge clk);
      ce = (lat == 2) ? if2.mem_ce    : if1.mem_ce;
      a  = (lat == 2) ? if2.mem_addr  : if1.mem_addr;
      v  = (lat == 2) ? if2.out_valid : if1.out_valid;
      d  = (lat == 2) ? if2.out_data  : if1.out_data;
      l  = (lat == 2) ? if2.out_last  : if1.out_last;
      dn = (lat == 2) ? if2.done      : if1.done;
      bz = (lat == 2) ? if2.busy      : if1.busy;
      e_ce = (c <= 4);
      e_v  = (c >= lat + 2) && (c <= lat + 5);
      chk($sformatf("L%0d_c%0d_ce", lat, c), ce, e_ce);
      if (e_ce) chk($sformatf("L%0d_c%0d_addr", lat, c), a, 14'(16 + c - 1));
      chk($sformatf("L%0d_c%0d_valid", lat, c), v, e_v);
      if (e_v) begin
        chk($sformatf("L%0d_c%0d_data", lat, c), d, 32'hA500_0010 + 32'(c - lat - 2));
        chk($sformatf("L%0d_c%0d_last", lat, c), l, (c == lat + 5));
      end
      chk($sformatf("L%0d_c%0d_done", lat, c), dn, (c == lat + 6));
      chk($sformatf("L%0d_c%0d_busy", lat, c), bz, (c <= lat + 5));
    end
  endtask

  initial begin
    int h0, n;
    bit found;
    logic [31:0] lcg;
    if2.start = 1'b0; if2.base_addr = '0; if2.count = '0; if2.out_ready = 1'b1;
    if1.start = 1'b0; if1.base_addr = '0; if1.count = '0; if1.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    basic_table(2);
    repeat (2) @(negedge clk);

    // Zero-length sweep: done one cycle after start, nothing else moves.
    start_cmd(2, 14'h0040, 15'd0);
    @(negedge clk);
    chk("zero_done", if2.done, 1);
    chk("zero_busy", if2.busy, 0);
    chk("zero_ce", if2.mem_ce, 0);
    chk("zero_valid", if2.out_valid, 0);
    @(negedge clk);
    chk("zero_done_pulse", if2.done, 0);

    // Start pulses during a busy sweep must be ignored.
    h0 = hs2;
    start_cmd(2, 14'h0100, 15'd8);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if2.start = 1'b1; if2.base_addr = 14'h3000; if2.count = 15'd3;
      @(posedge clk); #1;
      if2.start = 1'b0;
    end
    wait_done(2, 40, "busy_start_done");
    repeat (4) @(negedge clk);
    chk("busy_start_words", hs2 - h0, 8);
    chk("busy_start_sb_empty", q2.size(), 0);

    // Address wrap-around at the top of the array.
    aq2.delete();
    start_cmd(2, 14'h3FFE, 15'd4);
    wait_done(2, 30, "wrap_done");
    chk("wrap_addr_count", aq2.size(), 4);
    for (int i = 0; i < 4 && i < aq2.size(); i++)
      chk($sformatf("wrap_addr%0d", i), aq2[i], 14'(16'h3FFE + i));

    // Backpressure with pseudo-random ready and two 10-cycle stalls.
    h0 = hs2; max_os2 = 0; stall_viol = 0; lcg = 32'h1357_9BDF; found = 1'b0;
    start_cmd(2, 14'h0000, 15'd16);
    for (int cyc = 0; cyc < 400 && !found; cyc++) begin
      @(posedge clk); #1;
      if (if2.done === 1'b1) found = 1'b1;
      lcg = lcg * 32'd1103515245 + 32'd12345;
      if ((cyc >= 3 && cyc < 13) || (cyc >= 25 && cyc < 35)) if2.out_ready = 1'b0;
      else if2.out_ready = lcg[16];
    end
    if2.out_ready = 1'b1;
    chk("bp_done", found, 1);
    chk("bp_words", hs2 - h0, 16);
    chk("bp_sb_empty", q2.size(), 0);
    chk("bp_outstanding_le_4", (max_os2 <= 4), 1);
    chk("bp_outstanding_reached_4", max_os2, 4);
    chk("bp_stall_stable_violations", stall_viol, 0);

    // Reset on the cycle of the third handshake of an 8-word sweep.
    n = 0; found = 1'b0;
    start_cmd(2, 14'h0000, 15'd8);
    for (int i = 0; i < 40 && !found; i++) begin
      if (if2.out_valid === 1'b1 && if2.out_ready === 1'b1) begin
        n++;
        if (n == 3) begin rst = 1'b1; found = 1'b1; end
      end
      if (!found) begin @(posedge clk); #1; end
    end
    chk("rst_third_handshake_seen", found, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    q2.delete();
    h0 = hs2;
    start_cmd(2, 14'h0020, 15'd2);
    wait_done(2, 30, "post_rst_done");
    repeat (6) @(negedge clk);
    chk("post_rst_words", hs2 - h0, 2);
    chk("post_rst_sb_empty", q2.size(), 0);

    // RD_LAT=1 build, same basic scenario.
    basic_table(1);
    repeat (3) @(negedge clk);
    chk("lat1_words", hs1, 4);
    chk("lat1_sb_empty", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
